button_conditioner: RTL and testbench

- Conditions the raw board push-button (M18) into clean control signals for the traffic-light LED FSM directly downstream.
- Chain: 2-flop synchronizer, debounce state machine, long-press timer.
- Outputs: a debounced level, plus single-cycle press, release and long-press strobes, so consumers never edge-detect on their own.
- Runs on the 100 MHz board clock (E3).

---
 rtl/button_conditioner_pkg.sv | 22 ++
 rtl/button_conditioner_sync_2ff.sv | 28 ++
 rtl/button_conditioner.sv | 159 +++++++++++++++
 tb/tb_button_conditioner.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/button_conditioner_pkg.sv
// Shared types and timing constants for the push-button conditioner.
// State encoding is mirrored on o_r_state for debug LEDs.
package button_conditioner_pkg;

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_PRESS_WAIT   = 3'd1,
    ST_PRESSED      = 3'd2,
    ST_LONG_HELD    = 3'd3,
    ST_RELEASE_WAIT = 3'd4
  } state_e;

  localparam int CLK_HZ      = 100_000_000;
  localparam int DEBOUNCE_MS = 10;
  localparam int LONG_MS     = 1000;

  // Board-clock cycles in a span of milliseconds.
  function automatic int ms_to_cycles(input int ms);
    return (CLK_HZ / 1000) * ms;
  endfunction

endpackage

// File: rtl/button_conditioner_sync_2ff.sv
// Two-flop synchronizer for asynchronous board inputs.
// Width is parameterizable so other switches can share it.
module sync_2ff #(
  parameter int P_W = 1
) (
  input  logic           i_w_clk,
  input  logic           i_w_reset,
  input  logic [P_W-1:0] i_w_d,
  output logic [P_W-1:0] o_w_q
);

  logic [P_W-1:0] r_s1;
  logic [P_W-1:0] r_s2;

  // Metastability filter: only r_s2 is safe to consume.
  always_ff @(posedge i_w_clk or negedge i_w_reset) begin
    if (!i_w_reset) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= i_w_d;
      r_s2 <= r_s1;
    end
  end

  assign o_w_q = r_s2;

endmodule

// File: rtl/button_conditioner.sv
// Push-button conditioner: synchronizer, debounce FSM, long-press timer.
// Emits a clean level plus single-cycle press/release/long strobes.
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int P_DEBOUNCE_CYCLES = ms_to_cycles(DEBOUNCE_MS),
  parameter int P_LONG_CYCLES     = ms_to_cycles(LONG_MS),
  parameter int P_CNT_W           = 32
) (
  input  logic       i_w_clk,
  input  logic       i_w_reset,
  input  logic       i_w_button,
  output logic       o_r_level,
  output logic       o_r_press,
  output logic       o_r_release,
  output logic       o_r_long,
  output logic [2:0] o_r_state
);

  localparam logic [P_CNT_W-1:0] LP_ZERO = '0;
  localparam logic [P_CNT_W-1:0] LP_ONE  = P_CNT_W'(1);
  localparam logic [P_CNT_W-1:0] LP_DMAX =
    P_CNT_W'(P_DEBOUNCE_CYCLES - 1);
  localparam logic [P_CNT_W-1:0] LP_LMAX =
    P_CNT_W'(P_LONG_CYCLES - 1);

  logic [0:0]         w_sync;
  logic               w_s2;

  state_e             r_state;
  state_e             w_state_nxt;
  logic [P_CNT_W-1:0] r_dcnt;
  logic [P_CNT_W-1:0] w_dcnt_nxt;
  logic [P_CNT_W-1:0] r_lcnt;
  logic [P_CNT_W-1:0] w_lcnt_nxt;
  logic               r_long_seen;
  logic               w_long_seen_nxt;
  logic               w_level_nxt;
  logic               w_press_nxt;
  logic               w_release_nxt;
  logic               w_long_nxt;

  sync_2ff #(
    .P_W (1)
  ) u_sync (
    .i_w_clk   (i_w_clk),
    .i_w_reset (i_w_reset),
    .i_w_d     (i_w_button),
    .o_w_q     (w_sync)
  );

  assign w_s2 = w_sync[0];

  // State, counters and registered outputs.
  always_ff @(posedge i_w_clk or negedge i_w_reset) begin
    if (!i_w_reset) begin
      r_state     <= ST_IDLE;
      r_dcnt      <= '0;
      r_lcnt      <= '0;
      r_long_seen <= 1'b0;
      o_r_level   <= 1'b0;
      o_r_press   <= 1'b0;
      o_r_release <= 1'b0;
      o_r_long    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_dcnt      <= w_dcnt_nxt;
      r_lcnt      <= w_lcnt_nxt;
      r_long_seen <= w_long_seen_nxt;
      o_r_level   <= w_level_nxt;
      o_r_press   <= w_press_nxt;
      o_r_release <= w_release_nxt;
      o_r_long    <= w_long_nxt;
    end
  end

  // Next state and counter updates; a bounce restarts qualification.
  always_comb begin
    w_state_nxt = r_state;
    w_dcnt_nxt  = r_dcnt;
    w_lcnt_nxt  = r_lcnt;
    unique case (r_state)
      ST_IDLE: begin
        if (w_s2) begin
          w_state_nxt = ST_PRESS_WAIT;
          w_dcnt_nxt  = LP_ONE;
        end
      end
      ST_PRESS_WAIT: begin
        if (!w_s2) begin
          w_state_nxt = ST_IDLE;
          w_dcnt_nxt  = LP_ZERO;
        end else if (r_dcnt == LP_DMAX) begin
          w_state_nxt = ST_PRESSED;
          w_dcnt_nxt  = LP_ZERO;
          w_lcnt_nxt  = LP_ZERO;
        end else begin
          w_dcnt_nxt  = r_dcnt + LP_ONE;
        end
      end
      ST_PRESSED: begin
        if (!w_s2) begin
          w_state_nxt = ST_RELEASE_WAIT;
          w_dcnt_nxt  = LP_ONE;
        end else if (r_lcnt == LP_LMAX) begin
          w_state_nxt = ST_LONG_HELD;
        end else begin
          w_lcnt_nxt  = r_lcnt + LP_ONE;
        end
      end
      ST_LONG_HELD: begin
        if (!w_s2) begin
          w_state_nxt = ST_RELEASE_WAIT;
          w_dcnt_nxt  = LP_ONE;
        end
      end
      ST_RELEASE_WAIT: begin
        // Hold timer stays frozen while a release is qualifying.
        if (w_s2) begin
          w_state_nxt = r_long_seen ? ST_LONG_HELD
                                    : ST_PRESSED;
          w_dcnt_nxt  = LP_ZERO;
        end else if (r_dcnt == LP_DMAX) begin
          w_state_nxt = ST_IDLE;
          w_dcnt_nxt  = LP_ZERO;
        end else begin
          w_dcnt_nxt  = r_dcnt + LP_ONE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_dcnt_nxt  = LP_ZERO;
        w_lcnt_nxt  = LP_ZERO;
      end
    endcase
  end

  // Strobes fire on transitions; level follows the accepted state.
  always_comb begin
    w_press_nxt   = (r_state == ST_PRESS_WAIT) &&
                    (w_state_nxt == ST_PRESSED);
    w_release_nxt = (r_state == ST_RELEASE_WAIT) &&
                    (w_state_nxt == ST_IDLE);
    w_long_nxt    = (r_state == ST_PRESSED) &&
                    (w_state_nxt == ST_LONG_HELD);
    w_level_nxt   = (w_state_nxt == ST_PRESSED) ||
                    (w_state_nxt == ST_LONG_HELD) ||
                    (w_state_nxt == ST_RELEASE_WAIT);
    w_long_seen_nxt = r_long_seen;
    if (w_state_nxt == ST_LONG_HELD) begin
      w_long_seen_nxt = 1'b1;
    end else if (w_state_nxt == ST_IDLE) begin
      w_long_seen_nxt = 1'b0;
    end
  end

  assign o_r_state = r_state;

endmodule

// File: tb/tb_button_conditioner.sv
// Randomized scoreboard bench for button_conditioner.
// A run-length reference model predicts outputs at every clock edge.
module tb_button_conditioner;

  localparam int D = 4;
  localparam int L = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       raw = 1'b0;
  logic       level;
  logic       press;
  logic       release_s;
  logic       long_s;
  logic [2:0] state;

  int n_tests = 0;
  int n_fail  = 0;

  logic [6:0] exp_q [$];

  button_conditioner #(
    .P_DEBOUNCE_CYCLES (D),
    .P_LONG_CYCLES     (L),
    .P_CNT_W           (32)
  ) dut (
    .i_w_clk     (clk),
    .i_w_reset   (rst_n),
    .i_w_button  (raw),
    .o_r_level   (level),
    .o_r_press   (press),
    .o_r_release (release_s),
    .o_r_long    (long_s),
    .o_r_state   (state)
  );

  always #5 clk = ~clk;

  // Reference model: the level flips once D consecutive synchronized
  // samples disagree with it; the hold timer counts agreeing samples
  // after a press that are not the end of a release excursion.
  initial begin
    logic m_s1, m_s2, s, lvl, lfired, pr, rl, lg;
    int run, hold;
    logic [2:0] st;
    m_s1 = 0; m_s2 = 0; lvl = 0; lfired = 0;
    run = 0; hold = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_s1 = 0; m_s2 = 0; lvl = 0; lfired = 0;
        run = 0; hold = 0;
        exp_q.delete();
        exp_q.push_back(7'd0);
      end else begin
        s = m_s2;
        m_s2 = m_s1;
        m_s1 = raw;
        pr = 0; rl = 0; lg = 0;
        if (s != lvl) begin
          run++;
          if (run == D) begin
            lvl = s;
            run = 0;
            if (s) begin
              pr = 1; hold = 0; lfired = 0;
            end else begin
              rl = 1; lfired = 0;
            end
          end
        end else begin
          if (lvl && run == 0 && !lfired) begin
            hold++;
            if (hold == L) begin
              lg = 1; lfired = 1;
            end
          end
          run = 0;
        end
        if (!lvl) st = (run > 0) ? 3'd1 : 3'd0;
        else if (run > 0) st = 3'd4;
        else st = lfired ? 3'd3 : 3'd2;
        exp_q.push_back({lvl, pr, rl, lg, st});
      end
    end
  end

  // Monitor: every cycle the DUT presents a result; compare it.
  initial begin
    logic [6:0] e, a;
    forever begin
      @(negedge clk);
      a = {level, press, release_s, long_s, state};
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard_empty at %0t: got %b", $time, a);
      end else begin
        e = exp_q.pop_front();
        if (a !== e) begin
          n_fail++;
          $display("FAIL outputs at %0t: got %b want %b (lvl,pr,rl,lg,st)",
                   $time, a, e);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h want %0h", nm, $time, act, exp);
    end
  endtask

  initial begin
    int len;
    step(3);
    chk("reset_state", {29'd0, state}, 0);
    chk("reset_level", {31'd0, level}, 0);
    rst_n = 1;
    step(2);

    // Clean press, long hold, release.
    raw = 1;
    step(6);
    chk("press_lat", {31'd0, press}, 1);
    chk("press_level", {31'd0, level}, 1);
    step(1);
    chk("press_once", {31'd0, press}, 0);
    chk("pressed_state", {29'd0, state}, 2);
    step(9);
    chk("long_lat", {31'd0, long_s}, 1);
    chk("long_state", {29'd0, state}, 3);
    step(1);
    chk("long_once", {31'd0, long_s}, 0);
    step(9);
    raw = 0;
    step(6);
    chk("release_lat", {31'd0, release_s}, 1);
    chk("release_level", {31'd0, level}, 0);
    step(1);
    chk("idle_state", {29'd0, state}, 0);
    step(3);

    // Bounce on the rising edge.
    raw = 1; step(2);
    raw = 0; step(1);
    raw = 1; step(12);
    raw = 0; step(10);

    // Release glitches before and after the long strobe.
    raw = 1; step(11);
    raw = 0; step(2);
    raw = 1; step(20);
    chk("glitch_long_state", {29'd0, state}, 3);
    raw = 0; step(2);
    raw = 1; step(8);
    chk("glitch_after_long", {29'd0, state}, 3);
    raw = 0; step(10);

    // Asynchronous reset mid press qualification.
    raw = 1; step(4);
    chk("press_wait_state", {29'd0, state}, 1);
    rst_n = 0;
    #1;
    chk("async_reset_state", {29'd0, state}, 0);
    step(2);
    rst_n = 1;
    step(6);
    chk("press_after_reset", {31'd0, press}, 1);
    step(1);
    raw = 0; step(10);

    // Short tap must be ignored.
    raw = 1; step(3);
    raw = 0; step(10);
    chk("short_tap_level", {31'd0, level}, 0);

    // Random bouncing with occasional resets.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) len = $urandom_range(5, 25);
      else len = $urandom_range(1, 4);
      raw = ~raw;
      step(len);
      if ($urandom_range(0, 39) == 0) begin
        rst_n = 0;
        step(1);
        rst_n = 1;
      end
    end
    raw = 0;
    step(20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
